move_validator: RTL and testbench



---
 rtl/move_validator.sv | 225 ++++++++++++++++++++++
 tb/tb_move_validator.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/move_validator.sv
// ============================================================================
// Module      : move_validator
// Description : Snapshots the source/destination piles of a requested move,
//               scans them, and returns a solitaire legality verdict.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module move_validator #(
  parameter int STOCK_SLOTS = 24,
  parameter int TAB_SLOTS   = 19,
  parameter int CARD_W      = 7
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [3:0]                    source,
  input  logic [3:0]                    source_offset,
  input  logic [3:0]                    destination,
  input  logic [STOCK_SLOTS*CARD_W-1:0] stock_pile,
  input  logic [TAB_SLOTS*CARD_W-1:0]   tableau1,
  input  logic [TAB_SLOTS*CARD_W-1:0]   tableau2,
  input  logic [TAB_SLOTS*CARD_W-1:0]   tableau3,
  input  logic [TAB_SLOTS*CARD_W-1:0]   tableau4,
  input  logic [TAB_SLOTS*CARD_W-1:0]   tableau5,
  input  logic [TAB_SLOTS*CARD_W-1:0]   tableau6,
  input  logic [TAB_SLOTS*CARD_W-1:0]   tableau7,
  input  logic [4*CARD_W-1:0]           foundation_cards,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic                          legal,
  output logic [2:0]                    reason
);

  localparam int             c_pile_w  = STOCK_SLOTS * CARD_W;
  localparam int             c_pad_w   = (STOCK_SLOTS - TAB_SLOTS) * CARD_W;
  localparam logic [CARD_W-1:0] c_empty = {CARD_W{1'b1}};
  localparam logic [4:0]     c_last    = 5'(STOCK_SLOTS - 1);

  localparam logic [2:0] c_ok      = 3'd0;
  localparam logic [2:0] c_bad_idx = 3'd1;
  localparam logic [2:0] c_bad_src = 3'd2;
  localparam logic [2:0] c_bad_off = 3'd3;
  localparam logic [2:0] c_rank    = 3'd4;
  localparam logic [2:0] c_suit    = 3'd5;
  localparam logic [2:0] c_king    = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_CHECK, S_RESP} state_t;

  state_t r_state, w_next;

  logic [3:0]          r_src, r_off, r_dst;
  logic [c_pile_w-1:0] r_src_snap, r_dst_snap;
  logic [CARD_W-1:0]   r_fnd;
  logic [4:0]          r_cnt, r_src_depth, r_dst_top;
  logic                r_dst_has;
  logic                r_legal;
  logic [2:0]          r_reason;

  logic [c_pile_w-1:0] w_src_sel, w_dst_sel;
  logic [CARD_W-1:0]   w_fnd_sel, w_src_slot, w_dst_slot, w_card, w_top;
  logic [4:0]          w_card_idx;
  logic                w_is_fnd, w_fnd_empty, w_bad_idx, w_bad_off;
  logic                w_legal;
  logic [2:0]          w_reason;
  logic                w_unused_bits;

  function automatic logic [CARD_W-1:0] slot_at(input logic [c_pile_w-1:0] pile,
                                                input logic [4:0] idx);
    logic [CARD_W-1:0] card;
    card = c_empty;
    for (int i = 0; i < STOCK_SLOTS; i++) begin
      if (idx == 5'(i)) card = pile[i*CARD_W +: CARD_W];
    end
    return card;
  endfunction

  // Tableaux are padded with empty slots so both snapshots share one width.
  always_comb begin
    w_src_sel = '1;
    case (source)
      4'd0:    w_src_sel = stock_pile;
      4'd1:    w_src_sel = {{c_pad_w{1'b1}}, tableau1};
      4'd2:    w_src_sel = {{c_pad_w{1'b1}}, tableau2};
      4'd3:    w_src_sel = {{c_pad_w{1'b1}}, tableau3};
      4'd4:    w_src_sel = {{c_pad_w{1'b1}}, tableau4};
      4'd5:    w_src_sel = {{c_pad_w{1'b1}}, tableau5};
      4'd6:    w_src_sel = {{c_pad_w{1'b1}}, tableau6};
      4'd7:    w_src_sel = {{c_pad_w{1'b1}}, tableau7};
      default: w_src_sel = '1;
    endcase
  end

  always_comb begin
    w_dst_sel = '1;
    w_fnd_sel = c_empty;
    case (destination)
      4'd1:    w_dst_sel = {{c_pad_w{1'b1}}, tableau1};
      4'd2:    w_dst_sel = {{c_pad_w{1'b1}}, tableau2};
      4'd3:    w_dst_sel = {{c_pad_w{1'b1}}, tableau3};
      4'd4:    w_dst_sel = {{c_pad_w{1'b1}}, tableau4};
      4'd5:    w_dst_sel = {{c_pad_w{1'b1}}, tableau5};
      4'd6:    w_dst_sel = {{c_pad_w{1'b1}}, tableau6};
      4'd7:    w_dst_sel = {{c_pad_w{1'b1}}, tableau7};
      4'd8:    w_fnd_sel = foundation_cards[3*CARD_W +: CARD_W];
      4'd9:    w_fnd_sel = foundation_cards[2*CARD_W +: CARD_W];
      4'd10:   w_fnd_sel = foundation_cards[1*CARD_W +: CARD_W];
      4'd11:   w_fnd_sel = foundation_cards[0 +: CARD_W];
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = S_SCAN;
      end
      S_SCAN:  if (r_cnt == c_last) w_next = S_CHECK;
      S_CHECK: w_next = S_RESP;
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_src_slot = slot_at(r_src_snap, r_cnt);
  assign w_dst_slot = slot_at(r_dst_snap, r_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_src       <= '0;
      r_off       <= '0;
      r_dst       <= '0;
      r_src_snap  <= '1;
      r_dst_snap  <= '1;
      r_fnd       <= c_empty;
      r_cnt       <= '0;
      r_src_depth <= '0;
      r_dst_top   <= '0;
      r_dst_has   <= 1'b0;
      r_legal     <= 1'b0;
      r_reason    <= c_ok;
    end else begin
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_src       <= source;
          r_off       <= source_offset;
          r_dst       <= destination;
          r_src_snap  <= w_src_sel;
          r_dst_snap  <= w_dst_sel;
          r_fnd       <= w_fnd_sel;
          r_cnt       <= '0;
          r_src_depth <= '0;
          r_dst_top   <= '0;
          r_dst_has   <= 1'b0;
        end
        S_SCAN: begin
          if (w_src_slot != c_empty) r_src_depth <= r_src_depth + 5'd1;
          if (w_dst_slot != c_empty) begin
            r_dst_has <= 1'b1;
            r_dst_top <= r_cnt;
          end
          if (r_cnt != c_last) r_cnt <= r_cnt + 5'd1;
        end
        S_CHECK: begin
          r_legal  <= w_legal;
          r_reason <= w_reason;
        end
        default: ;
      endcase
    end
  end

  assign w_card_idx  = r_src_depth - 5'd1 - {1'b0, r_off};
  assign w_card      = slot_at(r_src_snap, w_card_idx);
  assign w_top       = slot_at(r_dst_snap, r_dst_top);
  assign w_is_fnd    = (r_dst >= 4'd8) && (r_dst <= 4'd11);
  assign w_fnd_empty = (r_fnd[6:3] == 4'hF);
  assign w_bad_idx   = (r_src > 4'd7) || (r_dst == 4'd0) || (r_dst > 4'd11) || (r_src == r_dst);
  assign w_bad_off   = ({1'b0, r_off} >= r_src_depth) || ((r_src == 4'd0) && (r_off != 4'd0))
                     || (w_is_fnd && (r_off != 4'd0));
  // Only rank and colour of these cards take part in the rules.
  assign w_unused_bits = ^{r_fnd[2:0], w_top[2]};

  // Foundation suit is implied by the destination index (8..11 -> H,C,D,S).
  always_comb begin
    w_legal  = 1'b0;
    w_reason = c_ok;
    if (w_bad_idx)         w_reason = c_bad_idx;
    else if (w_bad_off)    w_reason = c_bad_off;
    else if (!w_card[0])   w_reason = c_bad_src;
    else if (w_is_fnd) begin
      if (w_card[2:1] != r_dst[1:0]) w_reason = c_suit;
      else if (w_fnd_empty ? (w_card[6:3] != 4'd0)
                           : (w_card[6:3] != r_fnd[6:3] + 4'd1)) w_reason = c_rank;
      else w_legal = 1'b1;
    end else begin
      if (!r_dst_has) begin
        if (w_card[6:3] != 4'd12) w_reason = c_king;
        else                      w_legal  = 1'b1;
      end
      else if (!w_top[0] || (w_top[6:3] != w_card[6:3] + 4'd1)) w_reason = c_rank;
      else if (w_top[1] == w_card[1])                          w_reason = c_suit;
      else                                                     w_legal  = 1'b1;
    end
  end

  assign legal  = r_legal;
  assign reason = r_reason;

endmodule

`default_nettype wire

// File: tb/tb_move_validator.sv
// ============================================================================
// Module      : tb_move_validator
// Description : Directed self-checking bench for move_validator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_move_validator;

  localparam int SS = 24;
  localparam int TS = 19;
  localparam int CW = 7;

  logic            clk = 1'b0;
  logic            rst, req_valid, resp_ready;
  logic [3:0]      source, source_offset, destination;
  logic [SS*CW-1:0] stock;
  logic [TS*CW-1:0] tab [1:7];
  logic [4*CW-1:0] fnd;
  logic            req_ready, resp_valid, legal;
  logic [2:0]      reason;

  int n_cmp  = 0;
  int n_fail = 0;

  move_validator #(.STOCK_SLOTS(SS), .TAB_SLOTS(TS), .CARD_W(CW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .source(source), .source_offset(source_offset), .destination(destination),
    .stock_pile(stock), .tableau1(tab[1]), .tableau2(tab[2]), .tableau3(tab[3]),
    .tableau4(tab[4]), .tableau5(tab[5]), .tableau6(tab[6]), .tableau7(tab[7]),
    .foundation_cards(fnd), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .legal(legal), .reason(reason)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] mk(input int rank, input int suit, input bit up);
    return {rank[3:0], suit[1:0], up};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_piles();
    stock = '1;
    for (int i = 1; i <= 7; i++) tab[i] = '1;
    fnd = '1;
  endtask

  task automatic put_tab(input int n, input int slot, input logic [6:0] c);
    tab[n][slot*CW +: CW] = c;
  endtask

  // Issue one request from just after a clock edge, check latency/verdict/hold, then handshake.
  task automatic do_req(input string tag, input logic [3:0] s, input logic [3:0] o,
                        input logic [3:0] d, input logic exp_l, input logic [2:0] exp_r,
                        input int hold);
    int lat;
    chk({tag, "_rdy_idle"}, req_ready, 1);
    source = s; source_offset = o; destination = d; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, 25);
    chk({tag, "_legal"}, legal, exp_l);
    chk({tag, "_reason"}, reason, exp_r);
    chk({tag, "_rdy_busy"}, req_ready, 0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, resp_valid, 1);
      chk({tag, "_hold_legal"}, legal, exp_l);
      chk({tag, "_hold_reason"}, reason, exp_r);
      chk({tag, "_hold_rdy"}, req_ready, 0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk({tag, "_done_valid"}, resp_valid, 0);
  endtask

  initial begin
    int seen;
    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    source = '0; source_offset = '0; destination = '0;
    clear_piles();

    // Reset state, held for several cycles with resp_ready low
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rst_req_ready", req_ready, 1);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_legal", legal, 0);
      chk("rst_reason", reason, 0);
      @(posedge clk); #1;
    end

    // 7S onto 8H: legal, then held 3 cycles
    put_tab(2, 0, mk(6, 3, 1));
    put_tab(5, 0, mk(7, 0, 1));
    do_req("7S_on_8H", 4'd2, 4'd0, 4'd5, 1'b1, 3'd0, 3);
    // 8D is red too, so the move stays legal
    put_tab(5, 0, mk(7, 2, 1));
    do_req("7S_on_8D", 4'd2, 4'd0, 4'd5, 1'b1, 3'd0, 0);
    put_tab(5, 0, mk(7, 1, 1));
    do_req("7S_on_8C", 4'd2, 4'd0, 4'd5, 1'b0, 3'd5, 0);
    put_tab(5, 0, mk(8, 0, 1));
    do_req("7S_on_9H", 4'd2, 4'd0, 4'd5, 1'b0, 3'd4, 0);
    put_tab(5, 0, mk(7, 0, 0));
    do_req("7S_on_down", 4'd2, 4'd0, 4'd5, 1'b0, 3'd4, 0);

    // Stock ace of clubs to foundations
    clear_piles();
    stock[0 +: CW] = mk(0, 1, 1);
    do_req("AC_to_fC", 4'd0, 4'd0, 4'd9, 1'b1, 3'd0, 0);
    do_req("AC_to_fH", 4'd0, 4'd0, 4'd8, 1'b0, 3'd5, 0);
    do_req("stock_off1", 4'd0, 4'd1, 4'd9, 1'b0, 3'd3, 0);

    // Full stock: top card sits in the last slot
    for (int i = 0; i < SS - 1; i++) stock[i*CW +: CW] = mk(5, 0, 0);
    stock[(SS-1)*CW +: CW] = mk(1, 1, 1);
    fnd[2*CW +: CW] = mk(0, 1, 1);
    do_req("2C_on_AC_full", 4'd0, 4'd0, 4'd9, 1'b1, 3'd0, 0);
    fnd[2*CW +: CW] = mk(1, 1, 1);
    do_req("2C_on_2C", 4'd0, 4'd0, 4'd9, 1'b0, 3'd4, 0);

    // Empty tableau targets, face-down source, bad indices
    clear_piles();
    put_tab(1, 0, mk(11, 0, 1));
    do_req("Q_to_empty", 4'd1, 4'd0, 4'd3, 1'b0, 3'd6, 0);
    put_tab(1, 0, mk(12, 0, 1));
    do_req("K_to_empty", 4'd1, 4'd0, 4'd3, 1'b1, 3'd0, 0);
    put_tab(4, 0, mk(3, 1, 0));
    put_tab(4, 1, mk(5, 2, 0));
    put_tab(4, 2, mk(9, 3, 1));
    do_req("facedown_src", 4'd4, 4'd2, 4'd6, 1'b0, 3'd2, 0);
    do_req("src_eq_dst", 4'd3, 4'd0, 4'd3, 1'b0, 3'd1, 0);
    do_req("dst_12", 4'd1, 4'd0, 4'd12, 1'b0, 3'd1, 0);

    // Reset mid-scan aborts the request
    chk("abort_rdy_pre", req_ready, 1);
    source = 4'd1; source_offset = 4'd0; destination = 4'd3; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_req_ready", req_ready, 1);
    chk("abort_resp_valid", resp_valid, 0);
    chk("abort_legal", legal, 0);
    chk("abort_reason", reason, 0);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (resp_valid) seen++;
      @(posedge clk); #1;
    end
    chk("abort_no_resp", seen, 0);
    do_req("after_abort", 4'd1, 4'd0, 4'd3, 1'b1, 3'd0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
